// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: coin credit, per-item pricing, change return.
// Outputs are registered; busy_o decodes the VEND/CHANGE states.
module vending_machine_multi #(
  parameter int NUM_ITEMS = 4,
  parameter int CREDIT_W = 7,
  parameter int CREDIT_MAX = 60,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES =
    {7'd35, 7'd30, 7'd25, 7'd20}
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         nickel_i,
  input  logic                         dime_i,
  input  logic                         quarter_i,
  input  logic [$clog2(NUM_ITEMS)-1:0] select_i,
  input  logic                         vend_req_i,
  input  logic                         cancel_i,
  output logic [CREDIT_W-1:0]          credit_o,
  output logic                         dispense_o,
  output logic [$clog2(NUM_ITEMS)-1:0] item_o,
  output logic                         change_nickel_o,
  output logic                         change_dime_o,
  output logic                         deny_o,
  output logic                         coin_reject_o,
  output logic                         busy_o
);

  localparam int SEL_W = $clog2(NUM_ITEMS);
  localparam int SW = CREDIT_W + 1;

  typedef enum logic [1:0] {
    ACCUM,
    VEND,
    CHANGE
  } state_e;

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [SEL_W-1:0]    item_q, item_d;
  logic dispense_q, dispense_d;
  logic nickel_q, nickel_d;
  logic dime_q, dime_d;
  logic deny_q, deny_d;
  logic reject_q, reject_d;

  logic [1:0]          coin_cnt;
  logic                coin_any;
  logic [SW-1:0]       coin_val;
  logic [SW-1:0]       sum;
  logic [CREDIT_W-1:0] price;
  logic                sel_ok;

  always_comb begin
    price  = '0;
    sel_ok = 1'b0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (32'(select_i) == i) begin
        sel_ok = 1'b1;
        price  = PRICES[i*CREDIT_W +: CREDIT_W];
      end
    end
  end

  always_comb begin
    coin_cnt = {1'b0, nickel_i} + {1'b0, dime_i}
             + {1'b0, quarter_i};
    coin_any = nickel_i | dime_i | quarter_i;
    coin_val = '0;
    if (nickel_i)  coin_val = SW'(5);
    if (dime_i)    coin_val = SW'(10);
    if (quarter_i) coin_val = SW'(25);
    sum = {1'b0, credit_q} + coin_val;
  end

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    item_d     = item_q;
    dispense_d = 1'b0;
    nickel_d   = 1'b0;
    dime_d     = 1'b0;
    deny_d     = 1'b0;
    reject_d   = 1'b0;
    unique case (state_q)
      ACCUM: begin
        if (cancel_i) begin
          reject_d = coin_any;
          if (credit_q != '0) state_d = CHANGE;
        end else if (vend_req_i) begin
          reject_d = coin_any;
          if (sel_ok && credit_q >= price) begin
            state_d    = VEND;
            dispense_d = 1'b1;
            item_d     = select_i;
            credit_d   = credit_q - price;
          end else begin
            deny_d = 1'b1;
          end
        end else if (coin_any) begin
          // Simultaneous coins or overflow past the cap bounce back whole
          if (coin_cnt == 2'd1 && sum <= SW'(CREDIT_MAX))
            credit_d = sum[CREDIT_W-1:0];
          else
            reject_d = 1'b1;
        end
      end
      VEND: begin
        reject_d = coin_any;
        state_d  = (credit_q != '0) ? CHANGE : ACCUM;
      end
      CHANGE: begin
        reject_d = coin_any;
        if (credit_q == '0) begin
          state_d = ACCUM;
        end else if (credit_q >= CREDIT_W'(10)) begin
          dime_d   = 1'b1;
          credit_d = credit_q - CREDIT_W'(10);
        end else begin
          nickel_d = 1'b1;
          credit_d = credit_q - CREDIT_W'(5);
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ACCUM;
      credit_q   <= '0;
      item_q     <= '0;
      dispense_q <= 1'b0;
      nickel_q   <= 1'b0;
      dime_q     <= 1'b0;
      deny_q     <= 1'b0;
      reject_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      item_q     <= item_d;
      dispense_q <= dispense_d;
      nickel_q   <= nickel_d;
      dime_q     <= dime_d;
      deny_q     <= deny_d;
      reject_q   <= reject_d;
    end
  end

  assign credit_o        = credit_q;
  assign dispense_o      = dispense_q;
  assign item_o          = item_q;
  assign change_nickel_o = nickel_q;
  assign change_dime_o   = dime_q;
  assign deny_o          = deny_q;
  assign coin_reject_o   = reject_q;
  assign busy_o          = (state_q == VEND) || (state_q == CHANGE);

endmodule

// File: tb/tb_vending_machine_multi.sv
// Directed bench for vending_machine_multi with hand-computed expectations.
module tb_vending_machine_multi;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       nickel = 1'b0, dime = 1'b0, quarter = 1'b0;
  logic [1:0] sel = '0;
  logic       vreq = 1'b0, cancel = 1'b0;
  logic [6:0] credit;
  logic       disp;
  logic [1:0] item;
  logic       ch_n, ch_d, deny, rej, busy;

  int total = 0;
  int bad = 0;

  vending_machine_multi dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .nickel_i       (nickel),
    .dime_i         (dime),
    .quarter_i      (quarter),
    .select_i       (sel),
    .vend_req_i     (vreq),
    .cancel_i       (cancel),
    .credit_o       (credit),
    .dispense_o     (disp),
    .item_o         (item),
    .change_nickel_o(ch_n),
    .change_dime_o  (ch_d),
    .deny_o         (deny),
    .coin_reject_o  (rej),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  // One clock: apply inputs at negedge, sample 1ns after posedge.
  task automatic cyc(input logic n, input logic d, input logic q,
                     input logic v, input logic [1:0] s,
                     input logic c);
    @(negedge clk);
    nickel = n; dime = d; quarter = q;
    vreq = v; sel = s; cancel = c;
    @(posedge clk);
    #1;
    nickel = 0; dime = 0; quarter = 0;
    vreq = 0; cancel = 0;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 2'd0, 0);
  endtask

  task automatic drain();
    cyc(0, 0, 0, 0, 2'd0, 1);
    for (int i = 0; i < 20 && busy; i++) idle();
    chk("drain_busy", busy, 0);
    chk("drain_credit", credit, 0);
  endtask

  initial begin
    // Reset with inputs asserted: they must be ignored
    rst = 1;
    cyc(0, 0, 1, 0, 2'd0, 0);
    cyc(1, 0, 0, 1, 2'd0, 0);
    rst = 0;
    chk("rst_credit", credit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_disp", disp, 0);
    chk("rst_item", item, 0);
    chk("rst_rej", rej, 0);

    // quarter, dime, vend item0 -> 15 change
    cyc(0, 0, 1, 0, 2'd0, 0);
    chk("q_credit", credit, 25);
    cyc(0, 1, 0, 0, 2'd0, 0);
    chk("qd_credit", credit, 35);
    cyc(0, 0, 0, 1, 2'd0, 0);
    chk("v0_disp", disp, 1);
    chk("v0_item", item, 0);
    chk("v0_credit", credit, 15);
    chk("v0_busy", busy, 1);
    chk("v0_nodime", ch_d, 0);
    idle();
    chk("v0_chg_enter_disp", disp, 0);
    chk("v0_chg_enter_busy", busy, 1);
    idle();
    chk("v0_dime", ch_d, 1);
    chk("v0_dime_cr", credit, 5);
    idle();
    chk("v0_nick", ch_n, 1);
    chk("v0_nick_nodime", ch_d, 0);
    chk("v0_nick_cr", credit, 0);
    idle();
    chk("v0_done_busy", busy, 0);
    chk("v0_done_nick", ch_n, 0);

    // dime, vend item3 (35) -> deny
    cyc(0, 1, 0, 0, 2'd0, 0);
    cyc(0, 0, 0, 1, 2'd3, 0);
    chk("d3_deny", deny, 1);
    chk("d3_disp", disp, 0);
    chk("d3_credit", credit, 10);
    chk("d3_busy", busy, 0);
    idle();
    chk("d3_deny_once", deny, 0);
    drain();

    // 45 cents refund: 4 dimes, 1 nickel
    cyc(0, 0, 1, 0, 2'd0, 0);
    cyc(0, 1, 0, 0, 2'd0, 0);
    cyc(0, 1, 0, 0, 2'd0, 0);
    chk("r45_credit", credit, 45);
    cyc(0, 0, 0, 0, 2'd0, 1);
    chk("r45_busy", busy, 1);
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("r45_dime", ch_d, 1);
      chk("r45_dime_n", ch_n, 0);
      chk("r45_dime_cr", credit, 35 - 10 * i);
    end
    idle();
    chk("r45_nick", ch_n, 1);
    chk("r45_nick_cr", credit, 0);
    idle();
    chk("r45_end_busy", busy, 0);
    chk("r45_end_nick", ch_n, 0);

    // cap at 60 and multi-coin reject
    cyc(0, 0, 1, 0, 2'd0, 0);
    cyc(0, 0, 1, 0, 2'd0, 0);
    chk("cap_50", credit, 50);
    cyc(0, 0, 1, 0, 2'd0, 0);
    chk("cap_rej", rej, 1);
    chk("cap_credit", credit, 50);
    cyc(1, 1, 0, 0, 2'd0, 0);
    chk("multi_rej", rej, 1);
    chk("multi_credit", credit, 50);
    cyc(0, 1, 0, 0, 2'd0, 0);
    chk("exact_max", credit, 60);
    chk("exact_max_rej", rej, 0);
    drain();

    // exact price boundary: 20 denied for item1, bought for item0
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 2'd0, 0);
    chk("n4_credit", credit, 20);
    cyc(0, 0, 0, 1, 2'd1, 0);
    chk("short_deny", deny, 1);
    cyc(0, 0, 0, 1, 2'd0, 0);
    chk("exact_disp", disp, 1);
    chk("exact_credit", credit, 0);
    idle();
    chk("exact_no_chg", busy, 0);

    // item2 at 30, no change
    cyc(0, 0, 1, 0, 2'd0, 0);
    cyc(1, 0, 0, 0, 2'd0, 0);
    cyc(0, 0, 0, 1, 2'd2, 0);
    chk("i2_disp", disp, 1);
    chk("i2_item", item, 2);
    chk("i2_credit", credit, 0);
    idle();

    // vend + cancel together with 30 -> refund, coin in CHANGE rejected
    cyc(0, 0, 1, 0, 2'd0, 0);
    cyc(1, 0, 0, 0, 2'd0, 0);
    chk("vc_credit", credit, 30);
    cyc(0, 0, 0, 1, 2'd0, 1);
    chk("vc_nodisp", disp, 0);
    chk("vc_busy", busy, 1);
    chk("vc_credit_hold", credit, 30);
    cyc(0, 1, 0, 0, 2'd0, 0);
    chk("vc_dime1", ch_d, 1);
    chk("vc_rej", rej, 1);
    chk("vc_cr1", credit, 20);
    cyc(0, 0, 0, 1, 2'd0, 1);
    chk("vc_dime2", ch_d, 1);
    chk("vc_ign_deny", deny, 0);
    chk("vc_cr2", credit, 10);
    idle();
    chk("vc_dime3", ch_d, 1);
    chk("vc_cr3", credit, 0);
    idle();
    chk("vc_end", busy, 0);

    // reset mid-CHANGE forfeits 15
    cyc(0, 1, 0, 0, 2'd0, 0);
    cyc(1, 0, 0, 0, 2'd0, 0);
    cyc(0, 0, 0, 0, 2'd0, 1);
    chk("rc_busy", busy, 1);
    chk("rc_credit", credit, 15);
    rst = 1;
    idle();
    rst = 0;
    chk("rc_credit0", credit, 0);
    chk("rc_busy0", busy, 0);
    chk("rc_dime0", ch_d, 0);
    idle();
    chk("rc_dime_after", ch_d, 0);
    chk("rc_nick_after", ch_n, 0);
    chk("rc_credit_after", credit, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vending_machine_multi.md
VENDING_MACHINE_MULTI -- requirements
Module: vending_machine_multi

Interface
REQ-001 SHALL have parameter NUM_ITEMS, default 4, number of selectable products (≥2).
REQ-002 SHALL have parameter CREDIT_W, default 7, credit register width in cents.
REQ-003 SHALL have parameter CREDIT_MAX, default 60, maximum credit in cents; it is a multiple of 5 and < 2**CREDIT_W.
REQ-004 SHALL have parameter PRICES, packed NUM_ITEMS×CREDIT_W; item i price in cents at slice i; default item0=20, item1=25, item2=30, item3=35; each price a nonzero multiple of 5, ≤ CREDIT_MAX.
REQ-005 SHALL have ports (one per line):
  clk_i  in  1  sole clock, rising edge.
  rst_i  in  1  reset, synchronous, active-high.
  nickel_i  in  1  5-cent coin, one-cycle pulse.
  dime_i  in  1  10-cent coin, one-cycle pulse.
  quarter_i  in  1  25-cent coin, one-cycle pulse.
  select_i  in  $clog2(NUM_ITEMS)  product index, sampled with vend_req_i.
  vend_req_i  in  1  purchase request pulse.
  cancel_i  in  1  refund request pulse.
  credit_o  out  CREDIT_W  current credit / remaining change, cents.
  dispense_o  out  1  one-cycle product-release pulse.
  item_o  out  $clog2(NUM_ITEMS)  product index, valid while dispense_o=1.
  change_nickel_o  out  1  one-cycle pulse, eject one nickel.
  change_dime_o  out  1  one-cycle pulse, eject one dime.
  deny_o  out  1  one-cycle pulse, request refused.
  coin_reject_o  out  1  one-cycle pulse, inserted coin returned, not credited.
  busy_o  out  1  high in VEND or CHANGE.

Function
REQ-006 SHALL implement FSM with states ACCUM, VEND, CHANGE; all outputs registered.
REQ-007 In ACCUM, per-cycle priority SHALL be cancel_i > vend_req_i > coin; lower-priority coin in same cycle SHALL be rejected (coin_reject_o=1 next cycle).
REQ-008 Coin accepted in ACCUM only if exactly one coin input high and credit+value ≤ CREDIT_MAX; credit_o updates at next edge.
REQ-009 More than one coin input high in one cycle SHALL reject all (single coin_reject_o pulse), credit unchanged.
REQ-010 Coin arriving in VEND or CHANGE SHALL be rejected.
REQ-011 vend_req_i with credit ≥ PRICES[select_i] SHALL enter VEND: next cycle dispense_o=1, item_o=select_i (registered), credit_o=credit−price.
REQ-012 vend_req_i with credit < price, or select_i ≥ NUM_ITEMS, SHALL pulse deny_o next cycle; credit and state unchanged.
REQ-013 VEND lasts exactly one cycle, then CHANGE if credit_o>0, else ACCUM.
REQ-014 cancel_i in ACCUM with credit>0 SHALL enter CHANGE next cycle; with credit=0 no effect.
REQ-015 CHANGE SHALL emit one coin per cycle: dime if credit_o ≥ 10 else nickel; credit_o decremented same cycle as pulse; at credit_o=0 return to ACCUM next cycle, no pulse that cycle.
REQ-016 vend_req_i and cancel_i outside ACCUM SHALL be ignored (no deny_o).
REQ-017 change_nickel_o and change_dime_o SHALL never both be 1; dispense_o and change pulses never in same cycle.
REQ-018 Arithmetic in CREDIT_W bits; credit_o SHALL never exceed CREDIT_MAX nor underflow.

Reset
REQ-019 rst_i=1 at a rising edge SHALL set state ACCUM, credit_o=0, all pulse outputs 0, item_o=0, busy_o=0, regardless of state.
REQ-020 Reset mid-CHANGE SHALL forfeit remaining change; no further change pulses.
REQ-021 Inputs asserted during reset cycle SHALL be ignored.

Verification
REQ-022 quarter, dime, vend_req item0 -> dispense_o item0, credit_o 15, then change_dime_o, change_nickel_o, credit_o 0, ACCUM.
REQ-023 dime, vend_req item3 -> deny_o one cycle, credit_o stays 10, no dispense.
REQ-024 quarter, dime, dime (45), cancel -> change_dime_o ×4 then change_nickel_o ×1 on consecutive cycles, credit_o 0.
REQ-025 credit 50, quarter -> coin_reject_o, credit_o 50; nickel+dime same cycle -> coin_reject_o, credit unchanged.
REQ-026 vend_req and cancel same cycle with credit 30 -> refund 30 (dime ×3), no dispense; coin during CHANGE -> coin_reject_o.
REQ-027 rst_i during CHANGE with 15 remaining -> next cycle credit_o 0, no change pulses, busy_o 0.
